// File: rtl/dcache2_pkg.sv
// dcache2 shared types: FSM state encoding, geometry derivation, nibble placement.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dcache2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WBACK,
        FILL,
        FLUSH,
        FDONE
    } state_t;

    function automatic int calc_offb(input int line_length);
        return $clog2(line_length);
    endfunction

    function automatic int calc_idxb(input int nlines, input int ways);
        return $clog2(nlines / ways);
    endfunction

    function automatic int calc_tagw(input int pa, input int line_length,
                                     input int nlines, input int ways);
        return pa - calc_offb(line_length) - calc_idxb(nlines, ways);
    endfunction

    // Bursts move byte 0 high nibble first, then byte 0 low nibble, then byte 1 ...
    // Bytes sit little-endian in the line vector, so nibble k lands at this lsb.
    function automatic int nib_lsb(input int k);
        return (k / 2) * 8 + (((k % 2) == 0) ? 4 : 0);
    endfunction

endpackage

// File: rtl/dcache2_tags.sv
// dcache2 tag store: per way/set tag, valid, dirty; per set LRU bit; hit and victim lookup.
// Latency: lookups combinational; updates take effect at the next clk edge.
// Backpressure: none; caller sequences updates one per cycle.
// Ports: idx/tag lookup -> hit, hit_way, victim_*; pr_set/pr_way probe for the flush walk;
//        touch/fill/inv/clean/clr_all update strobes.
module dcache2_tags
    import dcache2_pkg::*;
#(
    parameter int SETS = 4,
    parameter int WAYS = 2,
    parameter int TAGW = 19,
    parameter int IDXB = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXB-1:0] idx,
    input  logic [TAGW-1:0] tag,
    output logic            hit,
    output logic            hit_way,
    output logic            victim_way,
    output logic            victim_valid,
    output logic            victim_dirty,
    output logic [TAGW-1:0] victim_tag,
    input  logic [IDXB-1:0] pr_set,
    input  logic            pr_way,
    output logic            pr_vd,
    output logic [TAGW-1:0] pr_tag,
    input  logic            touch,
    input  logic            touch_dirty,
    input  logic            fill,
    input  logic            fill_way,
    input  logic            inv,
    input  logic            clean,
    input  logic            clr_all
);

    logic [TAGW-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [SETS-1:0] lru_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // Descending scan so that the lowest-numbered invalid way wins over LRU.
    always_comb begin
        victim_way = lru_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim_way = 1'(w);
        end
    end

    assign victim_valid = valid_q[idx][victim_way];
    assign victim_dirty = dirty_q[idx][victim_way];
    assign victim_tag   = tag_q[idx][victim_way];
    assign pr_vd        = valid_q[pr_set][pr_way] & dirty_q[pr_set][pr_way];
    assign pr_tag       = tag_q[pr_set][pr_way];

    always_ff @(posedge clk) begin
        if (reset || clr_all) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (touch) begin
                lru_q[idx] <= (WAYS == 2) ? ~hit_way : 1'b0;
                if (touch_dirty) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (fill) begin
                valid_q[idx][fill_way] <= 1'b1;
                dirty_q[idx][fill_way] <= 1'b0;
            end
            if (inv) begin
                valid_q[pr_set][pr_way] <= 1'b0;
                dirty_q[pr_set][pr_way] <= 1'b0;
            end
            if (clean) dirty_q[pr_set][pr_way] <= 1'b0;
        end
    end

    // Tags are never reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill) tag_q[idx][fill_way] <= tag;
    end

endmodule

// File: rtl/dcache2.sv
// dcache2: 1/2-way write-back data cache between the LSU and a 4-bit burst memory bus.
// Latency: hit/error ack in the request cycle; miss acks 1 cycle after the last fill strobe.
// Backpressure: req is held until ack; memory paces bursts with mem_strobe, one nibble each.
// Ports: CPU side req/paddr/wmask/rsize/fault/wdata -> rdata/ack/err; flush_all/flush_write ->
//        flush_done; memory side mem_req/mem_we/mem_addr/mem_dout, mem_din/mem_strobe.
module dcache2
    import dcache2_pkg::*;
#(
    parameter int LINE_LENGTH = 8,
    parameter int NLINES      = 8,
    parameter int WAYS        = 2,
    parameter int RV          = 32,
    parameter int PA          = 24
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req,
    input  logic [PA-1:0]                        paddr,
    input  logic [RV/8-1:0]                      wmask,
    input  logic [1:0]                           rsize,
    input  logic                                 fault,
    input  logic [RV-1:0]                        wdata,
    output logic [RV-1:0]                        rdata,
    output logic                                 ack,
    output logic                                 err,
    input  logic                                 flush_all,
    input  logic                                 flush_write,
    output logic                                 flush_done,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [PA-calc_offb(LINE_LENGTH)-1:0] mem_addr,
    output logic [3:0]                           mem_dout,
    input  logic [3:0]                           mem_din,
    input  logic                                 mem_strobe
);

    localparam int OFFB  = calc_offb(LINE_LENGTH);
    localparam int SETS  = NLINES / WAYS;
    localparam int IDXB  = calc_idxb(NLINES, WAYS);
    localparam int TAGW  = calc_tagw(PA, LINE_LENGTH, NLINES, WAYS);
    localparam int LBITS = LINE_LENGTH * 8;
    localparam int NNIB  = 2 * LINE_LENGTH;
    localparam int CNTB  = $clog2(NNIB);
    localparam int NB    = RV / 8;
    localparam int RVB   = $clog2(NB);
    localparam int LIB   = $clog2(NLINES);

    state_t state_q, state_d;
    logic [CNTB-1:0] cnt_q;
    logic [LIB-1:0]  fptr_q;
    logic            fl_q;
    logic [TAGW-1:0] wb_tag_q;
    logic [IDXB-1:0] wb_set_q;
    logic            wb_way_q;
    logic [LBITS-1:0] data_q [NLINES];

    logic [IDXB-1:0] idx, pr_set;
    logic [TAGW-1:0] ptag, victim_tag, pr_tag;
    logic [OFFB-1:0] woff;
    logic            hit, hit_way, victim_way, victim_valid, victim_dirty, pr_way, pr_vd;
    logic            touch, touch_dirty, fill, inv, clean, clr_all;
    logic            latch_miss, latch_flush, fptr_clr, fptr_inc, last;
    logic [LIB-1:0]  hit_li, fill_li, wb_li;
    logic [1:0]      size;
    logic            misaligned;
    int              nbytes;

    assign idx     = paddr[OFFB+IDXB-1:OFFB];
    assign ptag    = paddr[PA-1:OFFB+IDXB];
    assign woff    = paddr[OFFB-1:0] >> RVB;
    assign pr_set  = IDXB'(int'(fptr_q) / WAYS);
    assign pr_way  = 1'(int'(fptr_q) % WAYS);
    assign hit_li  = LIB'(int'(hit_way) * SETS + int'(idx));
    assign fill_li = LIB'(int'(wb_way_q) * SETS + int'(idx));
    assign wb_li   = LIB'(int'(wb_way_q) * SETS + int'(wb_set_q));
    assign last    = (cnt_q == CNTB'(NNIB - 1));
    assign rdata   = data_q[hit_li][int'(woff) * RV +: RV];

    // Write access size comes from how many lanes the mask enables.
    always_comb begin
        nbytes = 0;
        for (int b = 0; b < NB; b++) nbytes += int'(wmask[b]);
        if (wmask == '0)      size = rsize;
        else if (nbytes > 2)  size = 2'd2;
        else if (nbytes == 2) size = 2'd1;
        else                  size = 2'd0;
    end

    assign misaligned = (size == 2'd1 && paddr[0]) || (size >= 2'd2 && paddr[1:0] != 2'b00);

    dcache2_tags #(.SETS(SETS), .WAYS(WAYS), .TAGW(TAGW), .IDXB(IDXB)) u_tags (
        .clk          (clk),
        .reset        (reset),
        .idx          (idx),
        .tag          (ptag),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .pr_set       (pr_set),
        .pr_way       (pr_way),
        .pr_vd        (pr_vd),
        .pr_tag       (pr_tag),
        .touch        (touch),
        .touch_dirty  (touch_dirty),
        .fill         (fill),
        .fill_way     (wb_way_q),
        .inv          (inv),
        .clean        (clean),
        .clr_all      (clr_all)
    );

    always_comb begin
        state_d     = state_q;
        ack         = 1'b0;
        err         = 1'b0;
        flush_done  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_dout    = '0;
        touch       = 1'b0;
        touch_dirty = 1'b0;
        fill        = 1'b0;
        inv         = 1'b0;
        clean       = 1'b0;
        clr_all     = 1'b0;
        latch_miss  = 1'b0;
        latch_flush = 1'b0;
        fptr_clr    = 1'b0;
        fptr_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_all) begin
                    clr_all = 1'b1;
                    state_d = FDONE;
                end else if (flush_write) begin
                    fptr_clr = 1'b1;
                    state_d  = FLUSH;
                end else if (req) begin
                    if (fault || misaligned) begin
                        ack = 1'b1;
                        err = 1'b1;
                    end else if (hit) begin
                        ack         = 1'b1;
                        touch       = 1'b1;
                        touch_dirty = (wmask != '0);
                    end else begin
                        latch_miss = 1'b1;
                        state_d    = (victim_valid && victim_dirty) ? WBACK : FILL;
                    end
                end
            end
            WBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {wb_tag_q, wb_set_q};
                mem_dout = data_q[wb_li][nib_lsb(int'(cnt_q)) +: 4];
                if (mem_strobe && last) begin
                    // During a flush the line stays valid until the walk revisits it clean.
                    clean   = fl_q;
                    state_d = fl_q ? FLUSH : FILL;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {ptag, idx};
                if (mem_strobe && last) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (pr_vd) begin
                    latch_flush = 1'b1;
                    state_d     = WBACK;
                end else begin
                    inv = 1'b1;
                    if (fptr_q == LIB'(NLINES - 1)) state_d = FDONE;
                    else                            fptr_inc = 1'b1;
                end
            end
            FDONE: begin
                flush_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fptr_q  <= '0;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mem_req && mem_strobe) cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (fptr_clr)      fptr_q <= '0;
            else if (fptr_inc) fptr_q <= fptr_q + 1'b1;
            if (fptr_clr)              fl_q <= 1'b1;
            else if (state_q == FDONE) fl_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_miss) begin
            wb_tag_q <= victim_tag;
            wb_set_q <= idx;
            wb_way_q <= victim_way;
        end else if (latch_flush) begin
            wb_tag_q <= pr_tag;
            wb_set_q <= pr_set;
            wb_way_q <= pr_way;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == FILL && mem_strobe)
            data_q[fill_li][nib_lsb(int'(cnt_q)) +: 4] <= mem_din;
        if (touch_dirty) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask[b]) data_q[hit_li][int'(woff) * RV + b * 8 +: 8] <= wdata[b * 8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache2.sv
// Directed bench for dcache2 with default geometry (8-byte lines, 8 lines, 2 ways, 32-bit, PA 24).
// Latency: n/a (bench).
// Backpressure: bench plays the memory, strobing one nibble every cycle of a burst.
module tb_dcache2;

    logic        clk = 1'b0;
    logic        reset, req, fault, flush_all, flush_write, mem_strobe;
    logic [23:0] paddr;
    logic [3:0]  wmask, mem_din, mem_dout;
    logic [1:0]  rsize;
    logic [31:0] wdata, rdata;
    logic        ack, err, flush_done, mem_req, mem_we;
    logic [20:0] mem_addr;
    logic [63:0] wb;
    int          errors = 0;
    int          checks = 0;
    int          pulses, reqs;

    dcache2 dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .paddr       (paddr),
        .wmask       (wmask),
        .rsize       (rsize),
        .fault       (fault),
        .wdata       (wdata),
        .rdata       (rdata),
        .ack         (ack),
        .err         (err),
        .flush_all   (flush_all),
        .flush_write (flush_write),
        .flush_done  (flush_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .mem_strobe  (mem_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [23:0] a, input logic [3:0] m,
                         input logic [31:0] d, input logic [1:0] s, input logic f);
        @(posedge clk); #1;
        req = r; paddr = a; wmask = m; wdata = d; rsize = s; fault = f;
        @(negedge clk);
    endtask

    // Streams are written as a hex literal read left to right: leftmost digit is nibble 0.
    task automatic burst(input string tag, input logic exp_we, input logic [20:0] exp_addr,
                         input logic [63:0] stream, input int nstr, input logic rst_last,
                         input int exp_wait, output logic [63:0] got);
        int n;
        got = '0;
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, 64'(n), 64'(exp_wait));
        check({tag, "_we"}, 64'(mem_we), 64'(exp_we));
        check({tag, "_addr"}, 64'(mem_addr), 64'(exp_addr));
        for (int k = 0; k < nstr; k++) begin
            @(posedge clk); #1;
            mem_strobe = 1'b1;
            mem_din    = stream[63 - 4 * k -: 4];
            if (rst_last && k == nstr - 1) reset = 1'b1;
            @(negedge clk);
            got[63 - 4 * k -: 4] = mem_dout;
        end
        @(posedge clk); #1;
        mem_strobe = 1'b0;
        mem_din    = 4'h0;
        reset      = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; paddr = '0; wmask = '0; rsize = '0; fault = 1'b0;
        wdata = '0; flush_all = 1'b0; flush_write = 1'b0; mem_strobe = 1'b0; mem_din = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ack", 64'(ack), 0);
        check("rst_err", 64'(err), 0);
        check("rst_flush_done", 64'(flush_done), 0);
        check("rst_mem_req", 64'(mem_req), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_mem_dout", 64'(mem_dout), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);

        // Cold read of word 0x10, then hits within the same line.
        drive(1, 24'h000010, 4'h0, 0, 2'd2, 0);
        check("cold_ack0", 64'(ack), 0);
        burst("cold", 0, 21'h2, 64'h123456789ABCDEF0, 16, 0, 1, wb);
        check("cold_ack", 64'(ack), 1);
        check("cold_rdata", 64'(rdata), 64'h78563412);
        check("cold_mem_req_fall", 64'(mem_req), 0);
        drive(1, 24'h000010, 4'h0, 0, 2'd2, 0);
        check("reread_ack", 64'(ack), 1);
        check("reread_rdata", 64'(rdata), 64'h78563412);
        drive(1, 24'h000014, 4'h0, 0, 2'd2, 0);
        check("word14_rdata", 64'(rdata), 64'hF0DEBC9A);
        drive(1, 24'h000016, 4'h0, 0, 2'd1, 0);
        check("half16_err", 64'(err), 0);
        check("half16_rdata", 64'(rdata[31:16]), 64'hF0DE);
        drive(1, 24'h000013, 4'h0, 0, 2'd0, 0);
        check("byte13_rdata", 64'(rdata[31:24]), 64'h78);

        // Byte store hit.
        drive(1, 24'h000011, 4'b0010, 32'h0000AB00, 2'd0, 0);
        check("wr_ack", 64'(ack), 1);
        check("wr_err", 64'(err), 0);
        drive(1, 24'h000010, 4'h0, 0, 2'd2, 0);
        check("wr_readback", 64'(rdata), 64'h7856AB12);
        check("wr_no_mem", 64'(mem_req), 0);

        // Conflict in set 0: lines 0x00 and 0x20, dirty 0x00, touch 0x20, then 0x40.
        drive(1, 24'h000000, 4'h0, 0, 2'd2, 0);
        burst("fill00", 0, 21'h0, 64'hA0A1A2A3A4A5A6A7, 16, 0, 1, wb);
        check("fill00_rdata", 64'(rdata), 64'hA3A2A1A0);
        drive(1, 24'h000020, 4'h0, 0, 2'd2, 0);
        check("fill20_ack0", 64'(ack), 0);
        burst("fill20", 0, 21'h4, 64'hB0B1B2B3B4B5B6B7, 16, 0, 1, wb);
        check("fill20_rdata", 64'(rdata), 64'hB3B2B1B0);
        drive(1, 24'h000000, 4'hF, 32'hC3C2C1C0, 2'd0, 0);
        check("wr00_ack", 64'(ack), 1);
        drive(1, 24'h000020, 4'h0, 0, 2'd2, 0);
        check("touch20_ack", 64'(ack), 1);
        drive(1, 24'h000040, 4'h0, 0, 2'd2, 0);
        check("miss40_ack0", 64'(ack), 0);
        burst("wb00", 1, 21'h0, 64'h0, 16, 0, 1, wb);
        check("wb00_stream", wb, 64'hC0C1C2C3A4A5A6A7);
        burst("fill40", 0, 21'h8, 64'hD0D1D2D3D4D5D6D7, 16, 0, 0, wb);
        check("fill40_rdata", 64'(rdata), 64'hD3D2D1D0);
        drive(1, 24'h000020, 4'h0, 0, 2'd2, 0);
        check("keep20_ack", 64'(ack), 1);
        drive(1, 24'h000000, 4'h0, 0, 2'd2, 0);
        check("gone00_ack0", 64'(ack), 0);
        burst("refill00", 0, 21'h0, 64'hE0E1E2E3E4E5E6E7, 16, 0, 1, wb);
        check("refill00_rdata", 64'(rdata), 64'hE3E2E1E0);

        // Second dirty line, then write-back flush.
        drive(1, 24'h000020, 4'b0001, 32'h000000EE, 2'd0, 0);
        check("wr20_ack", 64'(ack), 1);
        @(posedge clk); #1;
        req = 1'b0;
        flush_write = 1'b1;
        @(posedge clk); #1;
        flush_write = 1'b0;
        @(negedge clk);
        burst("flwb20", 1, 21'h4, 64'h0, 16, 0, 2, wb);
        check("flwb20_stream", wb, 64'hEEB1B2B3B4B5B6B7);
        burst("flwb10", 1, 21'h2, 64'h0, 16, 0, 4, wb);
        check("flwb10_stream", wb, 64'h12AB56789ABCDEF0);
        pulses = 0;
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (flush_done) pulses++;
            if (mem_req) reqs++;
        end
        check("flush_done_pulses", 64'(pulses), 1);
        check("flush_extra_bursts", 64'(reqs), 0);
        drive(1, 24'h000010, 4'h0, 0, 2'd2, 0);
        check("postflush_ack0", 64'(ack), 0);
        burst("postflush", 0, 21'h2, 64'h0123456789ABCDEF, 16, 0, 1, wb);
        check("postflush_rdata", 64'(rdata), 64'h67452301);

        // Errors: misaligned read, faulting write, misaligned halfword store.
        drive(1, 24'h000012, 4'h0, 0, 2'd2, 0);
        check("misal_ack", 64'(ack), 1);
        check("misal_err", 64'(err), 1);
        drive(0, 24'h000012, 4'h0, 0, 2'd2, 0);
        check("misal_no_mem", 64'(mem_req), 0);
        drive(1, 24'h000010, 4'hF, 32'hFFFFFFFF, 2'd0, 1);
        check("fault_ack", 64'(ack), 1);
        check("fault_err", 64'(err), 1);
        drive(1, 24'h000011, 4'b0011, 32'hFFFFFFFF, 2'd0, 0);
        check("misal_wr_err", 64'(err), 1);
        drive(1, 24'h000010, 4'h0, 0, 2'd2, 0);
        check("unchanged_err", 64'(err), 0);
        check("unchanged_rdata", 64'(rdata), 64'h67452301);

        // Invalidate-all flush, then reset in the middle of the refill.
        @(posedge clk); #1;
        req = 1'b0;
        flush_all = 1'b1;
        @(posedge clk); #1;
        flush_all = 1'b0;
        @(negedge clk);
        check("flush_all_done", 64'(flush_done), 1);
        drive(1, 24'h000010, 4'h0, 0, 2'd2, 0);
        check("flush_all_single", 64'(flush_done), 0);
        check("flush_all_miss", 64'(ack), 0);
        burst("rstfill", 0, 21'h2, 64'h9999999999999999, 5, 1, 1, wb);
        check("rst_burst_mem_req", 64'(mem_req), 0);
        check("rst_burst_ack", 64'(ack), 0);
        burst("refill", 0, 21'h2, 64'h1122334455667788, 16, 0, 1, wb);
        check("refill_ack", 64'(ack), 1);
        check("refill_rdata", 64'(rdata), 64'h44332211);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache2.md
# dcache2

Parametrised set-associative write-back data cache: the next generation of the nibble-bus dcache. It sits between the load/store unit and the 4-bit external memory bus. Unlike its predecessor it has its own fill/write-back sequencer, 1- or 2-way associativity with LRU, byte-mask writes at 16 or 32 bits, a whole-cache write-back flush, and misalignment checking.

## Interface
- LINE_LENGTH, 8: line size in bytes; power of 2, ≥4.
- NLINES, 8: total lines; power of 2, a multiple of WAYS.
- WAYS, 2: associativity; 1 or 2.
- RV, 32: CPU data width; 16 or 32.
- PA, 24: physical byte-address width.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- req  in  1  CPU access request; level, held until ack.
- paddr  in  PA  byte address.
- wmask  in  RV/8  byte-write enables; 0 means read.
- rsize  in  2  read size: 0 byte, 1 half, 2 word.
- fault  in  1  MMU fault qualifying req.
- wdata  in  RV  store data, lane-aligned.
- rdata  out  RV  load data, lane-aligned; valid with ack.
- ack  out  1  access complete.
- err  out  1  with ack: fault or misaligned; no state changed.
- flush_all  in  1  level: invalidate everything, discarding dirty data.
- flush_write  in  1  level: write back all dirty lines, then invalidate.
- flush_done  out  1  one-cycle pulse when a flush completes.
- mem_req  out  1  burst active.
- mem_we  out  1  burst is a write-back.
- mem_addr  out  PA-OFFB  line address.
- mem_dout  out  4  nibble to memory.
- mem_din  in  4  nibble from memory.
- mem_strobe  in  1  one nibble transferred this cycle.

## Operation
- OFFB=clog2(LINE_LENGTH), SETS=NLINES/WAYS, IDXB=clog2(SETS), TAGW=PA-OFFB-IDXB.
- Set index = paddr[OFFB+IDXB-1:OFFB]; tag = paddr[PA-1:OFFB+IDXB].
- Per way and set: tag, valid, dirty. Per set: 1 LRU bit, which names the least-recently-used way; tied 0 when WAYS=1.
- Alignment: halfword requires paddr[0]=0; word requires paddr[1:0]=0. Applies to reads by rsize and to writes by wmask span.
- The FSM has five states: IDLE, WBACK, FILL, FLUSH, FDONE.
- IDLE priority: flush_all, then flush_write, then req.
  - flush_all: clear all valid/dirty/LRU in one cycle; pulse flush_done.
  - flush_write: go to FLUSH.
  - req with fault or misalignment: ack=err=1 in the same cycle.
  - req that hits: ack in the same cycle. Masked bytes are written at that edge and dirty is set. LRU is updated to the other way.
  - req that misses: choose a victim. The first invalid way wins (way 0 first); otherwise the LRU way. Go to WBACK if the victim is valid and dirty, else go to FILL.
- WBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index}. After 2*LINE_LENGTH strobes, go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr = {ptag, index}. After the last strobe, write tag, set valid, clear dirty, return to IDLE. The request then hits.
- Nibble order in both directions: byte 0 high nibble, byte 0 low nibble, byte 1 high nibble, and so on. Nibble k uses counter value k.
- FLUSH: walk every (set, way) in ascending order. Each dirty valid line gets a WBACK burst. Every line is then invalidated. Finish in FDONE, which pulses flush_done and returns to IDLE.
- Flush inputs are only sampled in IDLE. A flush asserted during a burst waits for it to finish.
- Reset at any time: state goes to IDLE; all valid/dirty/LRU bits and the nibble counter are cleared. Data and tag arrays are not cleared.

## Timing
- Reset values: ack=0, err=0, flush_done=0, mem_req=0, mem_we=0, mem_dout=0, mem_addr=0. rdata is don't-care without ack.
- Hit or error: 0-cycle latency; ack is combinational from req in IDLE.
- Clean miss: mem_req rises the cycle after req; one nibble per mem_strobe cycle. Ack comes 1 cycle after the last fill strobe.
- Dirty miss: the WBACK burst, then FILL starts the following cycle.
- mem_req falls the cycle after the final strobe. mem_addr, mem_we and mem_dout are stable while mem_req=1 and there is no strobe.
- mem_strobe while mem_req=0 is ignored.
- Reset during a burst: mem_req=0 the next cycle. The counter never wraps past 2*LINE_LENGTH-1.

## Structure
- Package dcache2_pkg holds: the state enum; the OFFB/IDXB/TAGW derivation functions; the nibble-index-to-bit-slice helper.
- Sub-module dcache2_tags holds the tag/valid/dirty/LRU arrays. It provides hit, hit-way, victim-way, victim-dirty and victim-tag outputs.
- Data array, FSM and counter live in the top level.

## Test plan
- Cold read, word at 0x000010: mem_req with mem_addr=0x000002 and we=0. 16 nibbles from mem_din 0x1..0x8 pairs; bytes 0x12,0x34,0x56,0x78 give rdata=0x78563412 with ack. An immediate re-read acks in 0 cycles.
- Write hit, wmask=4'b0010 with wdata=0x0000AB00 to 0x000011: byte 1 becomes 0xAB, the line becomes dirty, and there is no memory traffic.
- Conflict: fill lines 0x00 and 0x20, dirty 0x00, touch 0x20, then read 0x40. WBACK of line 0x0 emits 16 nibbles in order, FILL follows at line 0x8, and way 0 is replaced.
- flush_write with 2 dirty lines: exactly 2 write bursts, then flush_done pulses once; every later access misses.
- Word read at 0x000012 → ack=err=1 at once, no mem_req. req with fault=1 → same, no state change.
- Reset asserted at the 5th fill strobe: mem_req=0 the next cycle. A re-read of the same address misses and does a full 16-nibble fill.
